// File: rtl/lighthouse_event_pkg.sv
// Shared constants, entry layout and status-word packing for the lighthouse event FIFO.
// Entry layout gains a timestamp field when LIGHTHOUSE_EVENT_TIMESTAMP_EN is defined.
package lighthouse_event_pkg;

    localparam int ID_W = 4;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd2;
    localparam logic [2:0] ADDR_OVERRUN = 3'd3;
    localparam logic [2:0] ADDR_FLUSH   = 3'd4;

    localparam int STATUS_EMPTY_BIT    = 27;
    localparam int STATUS_OVERFLOW_BIT = 26;

    localparam logic [31:0] FILLER_WORD = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
`ifdef LIGHTHOUSE_EVENT_TIMESTAMP_EN
        logic [31:0]     tstamp;
`endif
    } event_entry_t;

    function automatic logic [31:0] status_word(input logic [ID_W-1:0] id,
                                                input logic            empty,
                                                input logic            overflow,
                                                input logic [15:0]     count);
        logic [31:0] word;
        word                      = '0;
        word[31:28]               = id;
        word[STATUS_EMPTY_BIT]    = empty;
        word[STATUS_OVERFLOW_BIT] = overflow;
        word[15:0]                = count;
        return word;
    endfunction

endpackage

// File: rtl/lighthouse_event_fifo_if.sv
// Avalon-MM register port between the ARM core (master) and the event FIFO (slave).
interface lighthouse_event_fifo_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, write, writedata, read,
                    input  readdata, waitrequest);
    modport slave  (input  address, write, writedata, read,
                    output readdata, waitrequest);
endinterface

// File: rtl/event_sync_fifo.sv
// Single-clock show-ahead FIFO of event entries with push/pop/flush and a 16-bit occupancy count.
module event_sync_fifo
    import lighthouse_event_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  event_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output event_entry_t head,
    output logic [15:0]  count,
    output logic         empty,
    output logic         full,
    output logic         dropped
);
    localparam int PW = $clog2(DEPTH);

    event_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [15:0]    count_reg;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count_reg == 16'd0);
    assign full    = (count_reg == 16'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dropped = push && !push_ok && !flush;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + 16'(push_ok) - 16'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush && !reset) mem[wr_ptr_reg] <= push_entry;
    end

endmodule

// File: rtl/lighthouse_event_fifo.sv
// Sensor change detection, round-robin arbitration and Avalon register map in front of the event FIFO.
// Optional per-entry cycle timestamp: define LIGHTHOUSE_EVENT_TIMESTAMP_EN.
module lighthouse_event_fifo
    import lighthouse_event_pkg::*;
#(
    parameter int NUM_SENSORS = 16,
    parameter int DEPTH       = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SENSORS*32-1:0] sensor_data_i,
    lighthouse_event_fifo_if.slave   avalon
);
    localparam int SEL_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    logic [31:0]            prev_reg [NUM_SENSORS];
    logic [31:0]            hold_reg [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] pending_reg;
    logic [NUM_SENSORS-1:0] overrun_reg;
    logic [NUM_SENSORS-1:0] new_event;
    logic [NUM_SENSORS-1:0] grant_onehot;
    logic [SEL_W-1:0]       last_grant_reg;
    logic [SEL_W-1:0]       grant_sel;
    logic                   grant_valid;
    logic                   overflow_reg;

    logic                   wr_clear;
    logic                   wr_flush;
    logic                   rd_pop;

    event_entry_t           push_entry;
    event_entry_t           head;
    logic [15:0]            fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_dropped;
    logic [31:0]            readdata_comb;
    logic                   unused_ok;

    assign wr_clear = avalon.write && (avalon.address == ADDR_OVERRUN);
    assign wr_flush = avalon.write && (avalon.address == ADDR_FLUSH) && avalon.writedata[0];
    assign rd_pop   = avalon.read  && (avalon.address == ADDR_DATA);

    generate
        for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
            logic [31:0] word;
            assign word          = sensor_data_i[gi*32 +: 32];
            assign new_event[gi] = word[31] && (word != prev_reg[gi]);

            always_ff @(posedge clock) begin
                if (reset) begin
                    prev_reg[gi]    <= '0;
                    hold_reg[gi]    <= '0;
                    pending_reg[gi] <= 1'b0;
                    overrun_reg[gi] <= 1'b0;
                end else begin
                    prev_reg[gi] <= word;
                    if (new_event[gi]) hold_reg[gi] <= word;
                    pending_reg[gi] <= new_event[gi] || (pending_reg[gi] && !grant_onehot[gi]);
                    // Overrun only when an unpushed word is overwritten; set beats clear.
                    overrun_reg[gi] <= (overrun_reg[gi] && !wr_clear) ||
                                       (new_event[gi] && pending_reg[gi] && !grant_onehot[gi]);
                end
            end
        end
    endgenerate

    always_comb begin
        int idx;
        grant_valid  = 1'b0;
        grant_sel    = '0;
        grant_onehot = '0;
        idx          = 0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            idx = int'(last_grant_reg) + 1 + i;
            if (idx >= NUM_SENSORS) idx = idx - NUM_SENSORS;
            if (idx >= NUM_SENSORS) idx = idx - NUM_SENSORS;
            if (!grant_valid && pending_reg[idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_sel   = idx[SEL_W-1:0];
            end
        end
        if (grant_valid) grant_onehot[grant_sel] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_reg <= SEL_W'(NUM_SENSORS - 1);
            overflow_reg   <= 1'b0;
        end else begin
            if (grant_valid) last_grant_reg <= grant_sel;
            overflow_reg <= (overflow_reg && !wr_clear) || fifo_dropped;
        end
    end

`ifdef LIGHTHOUSE_EVENT_TIMESTAMP_EN
    logic [31:0] tstamp_reg;

    always_ff @(posedge clock) begin
        if (reset) tstamp_reg <= '0;
        else       tstamp_reg <= tstamp_reg + 32'd1;
    end
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.id   = ID_W'(grant_sel);
        push_entry.data = hold_reg[grant_sel];
`ifdef LIGHTHOUSE_EVENT_TIMESTAMP_EN
        push_entry.tstamp = tstamp_reg;
`endif
    end

    event_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (grant_valid),
        .push_entry (push_entry),
        .pop        (rd_pop),
        .flush      (wr_flush),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .dropped    (fifo_dropped)
    );

    always_comb begin
        readdata_comb = FILLER_WORD;
        case (avalon.address)
            ADDR_DATA:    readdata_comb = fifo_empty ? 32'd0 : head.data;
            ADDR_STATUS:  readdata_comb = status_word(fifo_empty ? '0 : head.id, fifo_empty,
                                                      overflow_reg, fifo_count);
`ifdef LIGHTHOUSE_EVENT_TIMESTAMP_EN
            ADDR_TSTAMP:  readdata_comb = fifo_empty ? 32'd0 : head.tstamp;
`else
            ADDR_TSTAMP:  readdata_comb = FILLER_WORD;
`endif
            ADDR_OVERRUN: readdata_comb = 32'(overrun_reg);
            ADDR_FLUSH:   readdata_comb = 32'd0;
            default:      readdata_comb = FILLER_WORD;
        endcase
    end

    assign avalon.readdata    = readdata_comb;
    assign avalon.waitrequest = 1'b0;
    assign unused_ok          = ^{avalon.writedata[31:1], fifo_full};

endmodule

// File: tb/tb_lighthouse_event_fifo.sv
// Directed bench for lighthouse_event_fifo: arbitration order, overrun, overflow, flush, reset, optional timestamps.
module tb_lighthouse_event_fifo;
    localparam int NS = 16;
    localparam int DP = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NS*32-1:0]  sens  = '0;
    int                vec_cnt = 0;
    int                err_cnt = 0;

    lighthouse_event_fifo_if bus();

    lighthouse_event_fifo #(.NUM_SENSORS(NS), .DEPTH(DP)) dut (
        .clock         (clock),
        .reset         (reset),
        .sensor_data_i (sens),
        .avalon        (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    function automatic logic [31:0] st(input int id, input bit e, input bit o, input int c);
        logic [3:0]  idv;
        logic [15:0] cv;
        idv = id[3:0];
        cv  = c[15:0];
        return {idv, e, o, 10'b0, cv};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b0;
        #1;
        d = bus.readdata;
    endtask

    task automatic pop_data(output logic [31:0] d);
        bus.address = 3'd0;
        bus.read    = 1'b1;
        #1;
        d = bus.readdata;
        @(posedge clock);
        #1;
        bus.read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(posedge clock);
        #1;
        bus.write = 1'b0;
    endtask

    task automatic set_sensor(input int n, input logic [31:0] w);
        sens[n*32 +: 32] = w;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        peek(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        pop_data(d);
        check_eq(tag, d, exp);
    endtask

    initial begin
        int          ids_b [3];
        logic [31:0] words_b [3];
        logic [31:0] d;
        ids_b   = '{0, 5, 15};
        words_b = '{32'h8000_00A0, 32'h8000_00A5, 32'h8000_00AF};

        bus.address = 3'd0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;

        // reset state
        check_reg("rst_status", 3'd1, 32'h0800_0000);
        check_reg("rst_data", 3'd0, 32'h0);
        check_reg("rst_addr5", 3'd5, 32'hDEAD_BEEF);
        check_reg("rst_addr7", 3'd7, 32'hDEAD_BEEF);
        check_reg("rst_overrun", 3'd3, 32'h0);
`ifdef LIGHTHOUSE_EVENT_TIMESTAMP_EN
        check_reg("rst_tstamp", 3'd2, 32'h0);
`else
        check_reg("rst_tstamp", 3'd2, 32'hDEAD_BEEF);
`endif
        check_eq("waitrequest", {31'b0, bus.waitrequest}, 32'h0);

        // three sensors at once: one push per cycle in order 0, 5, 15
        for (int k = 0; k < 3; k++) set_sensor(ids_b[k], words_b[k]);
        step(1);
        check_reg("rr_t1", 3'd1, st(0, 1, 0, 0));
        step(1);
        check_reg("rr_t2", 3'd1, st(0, 0, 0, 1));
        step(1);
        check_reg("rr_t3", 3'd1, st(0, 0, 0, 2));
        step(1);
        check_reg("rr_t4", 3'd1, st(0, 0, 0, 3));
        for (int k = 0; k < 3; k++) begin
            check_reg($sformatf("rr_head%0d", k), 3'd1, st(ids_b[k], 0, 0, 3 - k));
            check_pop($sformatf("rr_pop%0d", k), words_b[k]);
        end

        // next batch search resumes after 15, i.e. at 0: order 1, 14, 15
        set_sensor(1, 32'h8000_01A1);
        set_sensor(14, 32'h8000_01AE);
        set_sensor(15, 32'h8000_01AF);
        step(5);
        check_reg("b2_head", 3'd1, st(1, 0, 0, 3));
        check_pop("b2_pop1", 32'h8000_01A1);
        check_reg("b2_head14", 3'd1, st(14, 0, 0, 2));
        wr(3'd4, 32'h0);
        check_reg("flush_bit0_clear", 3'd1, st(14, 0, 0, 2));
        wr(3'd4, 32'h1);
        check_reg("flush", 3'd1, st(0, 1, 0, 0));
        check_reg("flush_data", 3'd0, 32'h0);

        // single sensor latency and pop
        set_sensor(3, 32'h8000_1234);
        step(1);
        check_reg("s3_t1", 3'd1, st(0, 1, 0, 0));
        step(2);
        check_reg("s3_t3", 3'd1, st(3, 0, 0, 1));
        check_pop("s3_pop", 32'h8000_1234);
        check_reg("s3_after", 3'd1, st(0, 1, 0, 0));
        // pop while empty: returns 0, count stays 0
        check_pop("empty_pop", 32'h0);
        check_reg("empty_after", 3'd1, st(0, 1, 0, 0));

        // sensor 2 changes twice while arbiter serves 4,5,6 -> overrun, latest word kept
        set_sensor(2, 32'h8000_2222);
        set_sensor(4, 32'h8000_4444);
        set_sensor(5, 32'h8000_5555);
        set_sensor(6, 32'h8000_6666);
        step(1);
        set_sensor(2, 32'h8000_2BBB);
        step(6);
        check_reg("ovr_bits", 3'd3, 32'h0000_0004);
        check_reg("ovr_status", 3'd1, st(4, 0, 0, 4));
        check_pop("ovr_pop4", 32'h8000_4444);
        check_pop("ovr_pop5", 32'h8000_5555);
        check_pop("ovr_pop6", 32'h8000_6666);
        check_reg("ovr_head2", 3'd1, st(2, 0, 0, 1));
        check_pop("ovr_pop2", 32'h8000_2BBB);
        wr(3'd3, 32'h0);
        check_reg("ovr_clear", 3'd3, 32'h0);
        check_reg("ovr_empty", 3'd1, st(0, 1, 0, 0));

        // DEPTH+1 events: last one dropped, overflow set
        for (int i = 0; i <= DP; i++) begin
            set_sensor(0, 32'h8000_0000 | 32'(i));
            step(1);
        end
        step(4);
        check_reg("full_status", 3'd1, st(0, 0, 1, DP));
        check_reg("full_head", 3'd0, 32'h8000_0000);

        // pop and push in the same cycle at full
        set_sensor(0, 32'h8000_0100);
        step(1);
        pop_data(d);
        check_eq("full_pp_data", d, 32'h8000_0000);
        check_reg("full_pp_count", 3'd1, st(0, 0, 1, DP));
        for (int i = 1; i < DP; i++) begin
            pop_data(d);
            if (d !== (32'h8000_0000 | 32'(i)) || i == 1 || i == DP - 1)
                check_eq($sformatf("drain%0d", i), d, 32'h8000_0000 | 32'(i));
        end
        check_pop("drain_last", 32'h8000_0100);
        check_reg("drain_status", 3'd1, st(0, 1, 1, 0));
        wr(3'd3, 32'hFFFF_FFFF);
        check_reg("ovf_clear", 3'd1, st(0, 1, 0, 0));

`ifdef LIGHTHOUSE_EVENT_TIMESTAMP_EN
        begin
            logic [31:0] ts1, ts2;
            set_sensor(6, 32'h8000_0306);
            step(10);
            set_sensor(6, 32'h8000_0406);
            step(5);
            check_reg("ts_count", 3'd1, st(6, 0, 0, 2));
            peek(3'd2, ts1);
            check_pop("ts_pop1", 32'h8000_0306);
            peek(3'd2, ts2);
            check_eq("ts_delta", ts2 - ts1, 32'd10);
            check_pop("ts_pop2", 32'h8000_0406);
        end
`endif

        // reset mid-operation wipes queued entries and sticky flags
        set_sensor(9, 32'h8000_0909);
        set_sensor(10, 32'h8000_0A0A);
        step(1);
        set_sensor(10, 32'h8000_0A0B);
        step(3);
        check_reg("pre_rst_status", 3'd1, st(9, 0, 0, 2));
        check_reg("pre_rst_overrun", 3'd3, 32'h0000_0400);
        reset = 1'b1;
        step(1);
        check_reg("mid_rst_status", 3'd1, 32'h0800_0000);
        check_reg("mid_rst_overrun", 3'd3, 32'h0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
